// File: rtl/hub75_input.sv
`timescale 1ns/1ps
`default_nettype none
// hub75_input: samples a HUB75 panel bus driven by an external controller and
// re-emits each latched row with its address, bit-plane and lit time as a stream beat.
module hub75_input #(
  parameter int NUM_COLS  = 64,
  parameter int SCAN_RATE = 32,
  parameter int PLANES    = 3,
  parameter int ON_TIME_W = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [2:0]                   hub_rgb0,
  input  logic [2:0]                   hub_rgb1,
  input  logic                         hub_clk,
  input  logic                         hub_latch,
  input  logic                         hub_oe,
  input  logic [$clog2(SCAN_RATE)-1:0] hub_address,
  output logic [3*NUM_COLS-1:0]        m_rgb0,
  output logic [3*NUM_COLS-1:0]        m_rgb1,
  output logic [$clog2(SCAN_RATE)-1:0] m_address,
  output logic [$clog2(PLANES)-1:0]    m_plane,
  output logic [ON_TIME_W-1:0]         m_on_time,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         short_err,
  output logic                         overflow_err
);
  localparam int AW = $clog2(SCAN_RATE);
  localparam int PW = $clog2(PLANES);
  localparam int CW = $clog2(NUM_COLS + 1);
  localparam logic [CW-1:0] COLS_FULL  = CW'(NUM_COLS);
  localparam logic [PW-1:0] LAST_PLANE = PW'(PLANES - 1);
  localparam logic [0:0] S_SHIFT   = 1'b0;
  localparam logic [0:0] S_DISPLAY = 1'b1;

  // bit 0: first stage, bit 1: synced copy, bit 2: delayed copy for edge detect
  logic [2:0]    clk_sync, latch_sync, oe_sync;
  logic [2:0]    rgb0_s1, rgb0_s2, rgb1_s1, rgb1_s2;
  logic [AW-1:0] addr_s1, addr_s2;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      clk_sync   <= 3'b000;
      latch_sync <= 3'b000;
      oe_sync    <= 3'b111;
      rgb0_s1    <= '0;
      rgb0_s2    <= '0;
      rgb1_s1    <= '0;
      rgb1_s2    <= '0;
      addr_s1    <= '0;
      addr_s2    <= '0;
    end else begin
      clk_sync   <= {clk_sync[1:0], hub_clk};
      latch_sync <= {latch_sync[1:0], hub_latch};
      oe_sync    <= {oe_sync[1:0], hub_oe};
      rgb0_s1    <= hub_rgb0;
      rgb0_s2    <= rgb0_s1;
      rgb1_s1    <= hub_rgb1;
      rgb1_s2    <= rgb1_s1;
      addr_s1    <= hub_address;
      addr_s2    <= addr_s1;
    end
  end

  logic clk_rise, latch_rise, oe_lit;
  assign clk_rise   = clk_sync[1] & ~clk_sync[2];
  assign latch_rise = latch_sync[1] & ~latch_sync[2];
  assign oe_lit     = ~oe_sync[1];

  logic [0:0]            state;
  logic [CW-1:0]         col_cnt;
  logic [3*NUM_COLS-1:0] shift_rgb0, shift_rgb1, pend_rgb0, pend_rgb1;
  logic [ON_TIME_W-1:0]  on_time;
  logic [AW-1:0]         last_addr;
  logic [PW-1:0]         last_plane;
  logic                  last_valid;
  logic [PW-1:0]         next_plane;
  logic                  finalize;

  // The pending row is always the most recently committed one, so last_* doubles as its tag.
  always_comb begin
    next_plane = '0;
    if (last_valid && addr_s2 == last_addr && last_plane < LAST_PLANE)
      next_plane = last_plane + 1'b1;
  end

  assign finalize = (state == S_DISPLAY) && (clk_rise || latch_rise);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= S_SHIFT;
      col_cnt    <= '0;
      shift_rgb0 <= '0;
      shift_rgb1 <= '0;
      pend_rgb0  <= '0;
      pend_rgb1  <= '0;
      on_time    <= '0;
      last_addr  <= '0;
      last_plane <= '0;
      last_valid <= 1'b0;
      short_err  <= 1'b0;
    end else begin
      short_err <= 1'b0;
      if (state == S_DISPLAY && oe_lit && !(&on_time))
        on_time <= on_time + 1'b1;
      // A latch edge wins over a coincident shift-clock edge, which is dropped.
      if (latch_rise) begin
        col_cnt <= '0;
        if (col_cnt == COLS_FULL) begin
          pend_rgb0  <= shift_rgb0;
          pend_rgb1  <= shift_rgb1;
          last_addr  <= addr_s2;
          last_plane <= next_plane;
          last_valid <= 1'b1;
          on_time    <= '0;
          state      <= S_DISPLAY;
        end else begin
          short_err <= 1'b1;
          state     <= S_SHIFT;
        end
      end else if (clk_rise) begin
        state <= S_SHIFT;
        if (col_cnt != COLS_FULL) begin
          shift_rgb0[int'(col_cnt) * 3 +: 3] <= rgb0_s2;
          shift_rgb1[int'(col_cnt) * 3 +: 3] <= rgb1_s2;
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m_rgb0       <= '0;
      m_rgb1       <= '0;
      m_address    <= '0;
      m_plane      <= '0;
      m_on_time    <= '0;
      m_tvalid     <= 1'b0;
      overflow_err <= 1'b0;
    end else if (finalize) begin
      if (!m_tvalid || m_tready) begin
        m_rgb0    <= pend_rgb0;
        m_rgb1    <= pend_rgb1;
        m_address <= last_addr;
        m_plane   <= last_plane;
        m_on_time <= on_time;
        m_tvalid  <= 1'b1;
      end else begin
        overflow_err <= 1'b1;
      end
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hub75_input.sv
`timescale 1ns/1ps
`default_nettype none
// tb_hub75_input: table rows, corner-case sequences and random rows checked against a row-level model.
module tb_hub75_input;
  localparam int NC = 64;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic [2:0]   hub_rgb0 = '0, hub_rgb1 = '0;
  logic         hub_clk = 1'b0, hub_latch = 1'b0, hub_oe = 1'b1;
  logic [4:0]   hub_address = '0;
  logic [191:0] m_rgb0, m_rgb1;
  logic [4:0]   m_address;
  logic [1:0]   m_plane;
  logic [15:0]  m_on_time;
  logic         m_tvalid, short_err, overflow_err;
  logic         m_tready = 1'b1;

  hub75_input dut (
    .clk_in(clk_in), .rst_in(rst_in), .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1),
    .hub_clk(hub_clk), .hub_latch(hub_latch), .hub_oe(hub_oe), .hub_address(hub_address),
    .m_rgb0(m_rgb0), .m_rgb1(m_rgb1), .m_address(m_address), .m_plane(m_plane),
    .m_on_time(m_on_time), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .short_err(short_err), .overflow_err(overflow_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [191:0] rgb0;
    logic [191:0] rgb1;
    int addr;
    int plane;
    int on_time;
  } beat_t;

  typedef struct {
    int npix;
    int pat;
    int addr;
    int oe;
    int plane;
  } row_vec_t;

  int vectors = 0, miscompares = 0;
  int tready_mode = 0;
  int short_cnt = 0, exp_short = 0;

  // Row-level model: what the panel controller has shifted, and which row is still lit.
  int         mdl_col = 0;
  logic [2:0] mr0[NC], mr1[NC];
  beat_t      pend;
  bit         disp = 1'b0;
  bit         last_valid = 1'b0;
  int         last_addr = 0, last_plane = 0;
  beat_t      expq[$];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic model_clk_edge(input logic [2:0] d0, input logic [2:0] d1);
    if (disp) begin
      expq.push_back(pend);
      disp = 1'b0;
    end
    if (mdl_col < NC) begin
      mr0[mdl_col] = d0;
      mr1[mdl_col] = d1;
      mdl_col++;
    end
  endtask

  task automatic model_latch(input int addr, input int ovr);
    int pl;
    if (disp) begin
      expq.push_back(pend);
      disp = 1'b0;
    end
    if (mdl_col == NC) begin
      pl = (last_valid && addr == last_addr && last_plane < 2) ? last_plane + 1 : 0;
      if (ovr >= 0) pl = ovr;
      for (int k = 0; k < NC; k++) begin
        pend.rgb0[3*k +: 3] = mr0[k];
        pend.rgb1[3*k +: 3] = mr1[k];
      end
      pend.addr = addr;
      pend.plane = pl;
      pend.on_time = 0;
      disp = 1'b1;
      last_valid = 1'b1;
      last_addr = addr;
      last_plane = pl;
    end else begin
      exp_short++;
    end
    mdl_col = 0;
  endtask

  task automatic send_pixels(input int n, input int pat);
    logic [2:0] d0, d1;
    for (int i = 0; i < n; i++) begin
      d0 = (pat != 0) ? 3'(i % 8) : 3'($urandom);
      d1 = (pat != 0) ? 3'b000 : 3'($urandom);
      hub_rgb0 = d0;
      hub_rgb1 = d1;
      tick(1);
      hub_clk = 1'b1;
      model_clk_edge(d0, d1);
      tick(3);
      hub_clk = 1'b0;
      tick(3);
    end
  endtask

  task automatic latch(input int addr, input bit coincide, input int ovr);
    hub_address = 5'(addr);
    tick(1);
    hub_latch = 1'b1;
    if (coincide) hub_clk = 1'b1;
    model_latch(addr, ovr);
    tick(3);
    hub_latch = 1'b0;
    hub_clk = 1'b0;
    tick(3);
    check("short_err_pulses", 192'(short_cnt), 192'(exp_short));
  endtask

  task automatic oe_on(input int n);
    if (n > 0) begin
      hub_oe = 1'b0;
      tick(n);
      hub_oe = 1'b1;
    end
    if (disp) pend.on_time += n;
    tick(4);
  endtask

  task automatic send_row(input int npix, input int pat, input int addr, input int oe, input int ovr);
    send_pixels(npix, pat);
    latch(addr, 1'b0, ovr);
    oe_on(oe);
  endtask

  task automatic check_zero_outputs();
    check("rst_m_tvalid", 192'(m_tvalid), 192'(0));
    check("rst_short_err", 192'(short_err), 192'(0));
    check("rst_overflow_err", 192'(overflow_err), 192'(0));
    check("rst_m_rgb0", m_rgb0, 192'(0));
    check("rst_m_rgb1", m_rgb1, 192'(0));
    check("rst_m_address", 192'(m_address), 192'(0));
    check("rst_m_plane", 192'(m_plane), 192'(0));
    check("rst_m_on_time", 192'(m_on_time), 192'(0));
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      case (tready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Every accepted beat must be the next row the model expects.
  always @(negedge clk_in) begin
    beat_t b;
    if (rst_in && short_err) short_cnt++;
    if (rst_in && m_tvalid && m_tready) begin
      check("beat_expected", 192'(expq.size() != 0), 192'(1));
      if (expq.size() != 0) begin
        b = expq.pop_front();
        check("beat_rgb0", m_rgb0, b.rgb0);
        check("beat_rgb1", m_rgb1, b.rgb1);
        check("beat_address", 192'(m_address), 192'(b.addr));
        check("beat_plane", 192'(m_plane), 192'(b.plane));
        check("beat_on_time", 192'(m_on_time), 192'(b.on_time));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    row_vec_t tbl[8];
    beat_t    dropped;
    int       np;
    tbl[0] = '{npix: 64, pat: 1, addr: 5, oe: 40, plane: 0};
    tbl[1] = '{npix: 64, pat: 0, addr: 9, oe: 10, plane: 0};
    tbl[2] = '{npix: 64, pat: 0, addr: 9, oe: 12, plane: 1};
    tbl[3] = '{npix: 64, pat: 0, addr: 9, oe: 14, plane: 2};
    tbl[4] = '{npix: 64, pat: 0, addr: 9, oe: 16, plane: 0};
    tbl[5] = '{npix: 63, pat: 0, addr: 9, oe: 0,  plane: -1};
    tbl[6] = '{npix: 64, pat: 0, addr: 3, oe: 7,  plane: 0};
    tbl[7] = '{npix: 64, pat: 0, addr: 3, oe: 0,  plane: 1};

    tick(3);
    check_zero_outputs();
    rst_in = 1'b1;
    tick(3);

    for (int i = 0; i < 8; i++)
      send_row(tbl[i].npix, tbl[i].pat, tbl[i].addr, tbl[i].oe, tbl[i].plane);
    send_pixels(1, 0);
    latch(0, 1'b0, -1);
    tick(5);

    // Output stalled: the first row is held, the second is dropped.
    tready_mode = 2;
    tick(2);
    send_row(64, 0, 1, 3, -1);
    send_row(64, 0, 2, 4, -1);
    send_pixels(1, 0);
    tick(6);
    check("ovf_m_tvalid", 192'(m_tvalid), 192'(1));
    check("ovf_flag", 192'(overflow_err), 192'(1));
    dropped = expq.pop_back();
    check("ovf_held_address", 192'(m_address), 192'(expq[0].addr));
    check("ovf_held_rgb0", m_rgb0, expq[0].rgb0);
    latch(0, 1'b0, -1);
    tick(10);
    check("ovf_sticky", 192'(overflow_err), 192'(1));
    check("ovf_held_rgb1", m_rgb1, expq[0].rgb1);
    check("ovf_held_on_time", 192'(m_on_time), 192'(expq[0].on_time));
    tready_mode = 0;
    tick(5);
    check("ovf_sticky_after_accept", 192'(overflow_err), 192'(1));

    // Reset in the middle of a row.
    send_pixels(30, 0);
    rst_in = 1'b0;
    tick(2);
    check_zero_outputs();
    rst_in = 1'b1;
    disp = 1'b0;
    last_valid = 1'b0;
    mdl_col = 0;
    tick(3);
    send_row(64, 0, 5, 20, -1);

    // Shift clock and latch rising together: only the latch counts.
    send_pixels(64, 0);
    latch(6, 1'b1, -1);
    oe_on(8);
    send_row(64, 0, 6, 5, -1);

    tready_mode = 1;
    for (int r = 0; r < 30; r++) begin
      np = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 63)) : 64;
      send_row(np, 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 30)), -1);
    end
    send_pixels(1, 0);
    latch(0, 1'b0, -1);
    tready_mode = 0;
    tick(20);
    check("undelivered_beats", 192'(expq.size()), 192'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
